// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM and its clear sweep.
package mem_pkg;

  localparam int MAX_WIDTH = 256;
  localparam int MAX_LANES = MAX_WIDTH / 8;

  typedef logic [MAX_WIDTH-1:0] word_t;
  typedef logic [MAX_LANES-1:0] be_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  function automatic int lane_bits(input int width_bits);
    return $clog2(width_bits / 8);
  endfunction

  function automatic int idx_bits(input int depth_words);
    return $clog2(depth_words);
  endfunction

  // Lanes with be[k]=1 take new_word, the rest keep old_word.
  function automatic word_t merge_lanes(input word_t old_word, input word_t new_word, input be_t be);
    word_t r;
    r = old_word;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (be[k]) r[8*k +: 8] = new_word[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_clear_sweep.sv
// Post-reset sequencer: optionally zeroes every word once, then raises ready.
//   state    | meaning
//   ST_RESET | held in reset or first edge after release
//   ST_CLEAR | writing zero to word[count], one word per edge
//   ST_READY | sweep done, ports live until next reset
module mem_clear_sweep
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 64,
  parameter int IDX_BITS       = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                ready,
  output logic                clr_we,
  output logic [IDX_BITS-1:0] clr_idx
);

  state_t              state;
  logic [IDX_BITS-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RESET;
      count <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          count <= '0;
          state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end
        ST_CLEAR: begin
          count <= count + 1'b1;
          if (count == IDX_BITS'(DEPTH_WORDS - 1)) state <= ST_READY;
        end
        default: state <= ST_READY;
      endcase
    end
  end

  assign ready   = (state == ST_READY);
  assign clr_we  = (state == ST_CLEAR);
  assign clr_idx = count;

endmodule

// File: rtl/mem_dual_be.sv
// True dual-port word RAM with per-byte write enables, priority-resolved
// same-lane collisions, selectable read latency and a post-reset clear sweep.
module mem_dual_be
  import mem_pkg::*;
#(
  parameter int    WIDTH_BITS     = 32,
  parameter int    DEPTH_WORDS    = 64,
  parameter int    ADDR_BITS      = 32,
  parameter int    READ_LATENCY   = 1,
  parameter string FILE           = "",
  parameter int    CLEAR_ON_RESET = 1,
  parameter int    PRIORITY_PORT  = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    ready,
  input  logic [WIDTH_BITS-1:0]   data_0,
  input  logic [ADDR_BITS-1:0]    address_0,
  input  logic                    wren_0,
  input  logic [WIDTH_BITS/8-1:0] byteen_0,
  output logic [WIDTH_BITS-1:0]   q_0,
  input  logic [WIDTH_BITS-1:0]   data_1,
  input  logic [ADDR_BITS-1:0]    address_1,
  input  logic                    wren_1,
  input  logic [WIDTH_BITS/8-1:0] byteen_1,
  output logic [WIDTH_BITS-1:0]   q_1,
  output logic                    collision
);

  localparam int LANE_BITS = lane_bits(WIDTH_BITS);
  localparam int IDX_BITS  = idx_bits(DEPTH_WORDS);

  if (CLEAR_ON_RESET != 0 && FILE != "") begin : g_cfg_err
    $fatal(1, "mem_dual_be: CLEAR_ON_RESET=1 would erase the FILE image");
  end
  if (WIDTH_BITS > MAX_WIDTH) begin : g_width_err
    $fatal(1, "mem_dual_be: WIDTH_BITS exceeds mem_pkg::MAX_WIDTH");
  end

  logic [WIDTH_BITS-1:0] mem [DEPTH_WORDS];

  logic                clr_we;
  logic [IDX_BITS-1:0] clr_idx;

  mem_clear_sweep #(
    .DEPTH_WORDS   (DEPTH_WORDS),
    .IDX_BITS      (IDX_BITS),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_sweep (
    .clock  (clock),
    .reset_n(reset_n),
    .ready  (ready),
    .clr_we (clr_we),
    .clr_idx(clr_idx)
  );

  // Low lane bits and bits above the index are don't-care by design.
  logic unused_addr;
  assign unused_addr = ^{address_0, address_1};

  logic [IDX_BITS-1:0] idx_0, idx_1;
  assign idx_0 = address_0[LANE_BITS +: IDX_BITS];
  assign idx_1 = address_1[LANE_BITS +: IDX_BITS];

  logic same_idx;
  assign same_idx = wren_0 && wren_1 && (idx_0 == idx_1);

  word_t                 m_0, m_1, m_lo, m_both;
  logic [WIDTH_BITS-1:0] wr_0, wr_1, wr_both;

  // Same-word writes: apply the losing port first so the priority port overwrites shared lanes.
  always_comb begin
    m_0  = merge_lanes(word_t'(mem[idx_0]), word_t'(data_0), be_t'(byteen_0));
    m_1  = merge_lanes(word_t'(mem[idx_1]), word_t'(data_1), be_t'(byteen_1));
    m_lo = '0;
    m_both = '0;
    if (PRIORITY_PORT == 0) begin
      m_lo   = merge_lanes(word_t'(mem[idx_0]), word_t'(data_1), be_t'(byteen_1));
      m_both = merge_lanes(m_lo, word_t'(data_0), be_t'(byteen_0));
    end else begin
      m_lo   = merge_lanes(word_t'(mem[idx_0]), word_t'(data_0), be_t'(byteen_0));
      m_both = merge_lanes(m_lo, word_t'(data_1), be_t'(byteen_1));
    end
    wr_0    = m_0[WIDTH_BITS-1:0];
    wr_1    = m_1[WIDTH_BITS-1:0];
    wr_both = m_both[WIDTH_BITS-1:0];
  end

  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (ready) begin
      if (same_idx) begin
        mem[idx_0] <= wr_both;
      end else begin
        if (wren_0) mem[idx_0] <= wr_0;
        if (wren_1) mem[idx_1] <= wr_1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) collision <= 1'b0;
    else          collision <= ready && same_idx && (|(byteen_0 & byteen_1));
  end

  if (READ_LATENCY == 1) begin : g_rd_reg
    logic [WIDTH_BITS-1:0] q_reg_0, q_reg_1;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q_reg_0 <= '0;
        q_reg_1 <= '0;
      end else begin
        q_reg_0 <= ready ? mem[idx_0] : '0;
        q_reg_1 <= ready ? mem[idx_1] : '0;
      end
    end
    assign q_0 = q_reg_0;
    assign q_1 = q_reg_1;
  end else begin : g_rd_comb
    assign q_0 = ready ? mem[idx_0] : '0;
    assign q_1 = ready ? mem[idx_1] : '0;
  end

endmodule

// File: tb/tb_mem_dual_be.sv
// Directed bench for mem_dual_be: one registered-read and one combinational-read
// instance share stimulus and are checked against hand-computed values.
module tb_mem_dual_be;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_0 = '0, data_1 = '0, address_0 = '0, address_1 = '0;
  logic        wren_0 = 1'b0, wren_1 = 1'b0;
  logic [3:0]  byteen_0 = '0, byteen_1 = '0;

  logic        ready_r, ready_c, col_r, col_c;
  logic [31:0] q0_r, q1_r, q0_c, q1_c;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_dual_be #(.READ_LATENCY(1)) u_reg (
    .clock(clock), .reset_n(reset_n), .ready(ready_r),
    .data_0(data_0), .address_0(address_0), .wren_0(wren_0), .byteen_0(byteen_0), .q_0(q0_r),
    .data_1(data_1), .address_1(address_1), .wren_1(wren_1), .byteen_1(byteen_1), .q_1(q1_r),
    .collision(col_r)
  );

  mem_dual_be #(.READ_LATENCY(0)) u_comb (
    .clock(clock), .reset_n(reset_n), .ready(ready_c),
    .data_0(data_0), .address_0(address_0), .wren_0(wren_0), .byteen_0(byteen_0), .q_0(q0_c),
    .data_1(data_1), .address_1(address_1), .wren_1(wren_1), .byteen_1(byteen_1), .q_1(q1_c),
    .collision(col_c)
  );

  typedef struct {
    logic        w0;
    logic [31:0] a0, d0;
    logic [3:0]  b0;
    logic        w1;
    logic [31:0] a1, d1;
    logic [3:0]  b1;
    logic [31:0] r0, r1, e0, e1;
    logic        col;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_r && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int  n;
    logic q_bad, col_bad;

    vecs[0] = '{1, 32'h10, 32'h11111111, 4'h3, 1, 32'h12, 32'h22222222, 4'h6,
                32'h10, 32'h11, 32'h00221111, 32'h00221111, 1};
    vecs[1] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 32'h0, 4'h0,
                32'h10, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[2] = '{0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 32'h000000AA, 4'h1,
                32'h13, 32'h10, 32'hDEADBEAA, 32'hDEADBEAA, 0};
    vecs[3] = '{1, 32'h100, 32'h5A5A5A5A, 4'hF, 0, 32'h0, 32'h0, 4'h0,
                32'h000, 32'h200, 32'h5A5A5A5A, 32'h5A5A5A5A, 0};
    vecs[4] = '{1, 32'h20, 32'h12345678, 4'hF, 1, 32'h24, 32'h9ABCDEF0, 4'hF,
                32'h20, 32'h24, 32'h12345678, 32'h9ABCDEF0, 0};
    vecs[5] = '{1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 32'h0, 4'h0,
                32'h20, 32'h24, 32'h12345678, 32'h9ABCDEF0, 0};
    vecs[6] = '{1, 32'h30, 32'hAAAAAAAA, 4'hC, 1, 32'h31, 32'hBBBBBBBB, 4'h3,
                32'h30, 32'h30, 32'hAAAABBBB, 32'hAAAABBBB, 0};
    vecs[7] = '{1, 32'h40, 32'h01020304, 4'hF, 1, 32'h43, 32'hF0F0F0F0, 4'hF,
                32'h40, 32'h40, 32'h01020304, 32'h01020304, 1};
    vecs[8] = '{0, 32'h0, 32'h0, 4'h0, 1, 32'hFFFFFF3C, 32'hCAFEF00D, 4'hF,
                32'h3C, 32'h3C, 32'hCAFEF00D, 32'hCAFEF00D, 0};
    vecs[9] = '{1, 32'h50, 32'hA1B2C3D4, 4'h8, 1, 32'h50, 32'h11223344, 4'hC,
                32'h50, 32'h50, 32'hA1220000, 32'hA1220000, 1};

    // Reset state
    step();
    step();
    chk("rst_ready", {31'd0, ready_r}, 32'd0);
    chk("rst_q0_reg", q0_r, 32'd0);
    chk("rst_q0_comb", q0_c, 32'd0);
    chk("rst_collision", {31'd0, col_r}, 32'd0);

    // Sweep with writes hammering word 0 on both ports: must all be ignored
    wren_0 = 1; wren_1 = 1; byteen_0 = 4'hF; byteen_1 = 4'hF;
    data_0 = 32'hFFFFFFFF; data_1 = 32'hFFFFFFFF; address_0 = 0; address_1 = 0;
    reset_n = 1'b1;
    q_bad = 0; col_bad = 0;
    n = 0;
    while (!ready_r && n < 200) begin
      if (q0_r !== 0 || q1_r !== 0 || q0_c !== 0 || q1_c !== 0) q_bad = 1;
      if (col_r !== 0 || col_c !== 0) col_bad = 1;
      step();
      n++;
    end
    wren_0 = 0; wren_1 = 0;
    chk("sweep_edges", n, 32'd65);
    chk("sweep_q_zero", {31'd0, q_bad}, 32'd0);
    chk("sweep_no_collision", {31'd0, col_bad}, 32'd0);
    chk("ready_comb_inst", {31'd0, ready_c}, 32'd1);

    for (int i = 0; i < 64; i++) begin
      address_0 = i * 4;
      address_1 = (63 - i) * 4 + 1;
      step();
      chk($sformatf("clear_r0_w%0d", i), q0_r, 32'd0);
      chk($sformatf("clear_c1_w%0d", i), q1_c, 32'd0);
    end

    for (int v = 0; v < 10; v++) begin
      wren_0 = vecs[v].w0; address_0 = vecs[v].a0; data_0 = vecs[v].d0; byteen_0 = vecs[v].b0;
      wren_1 = vecs[v].w1; address_1 = vecs[v].a1; data_1 = vecs[v].d1; byteen_1 = vecs[v].b1;
      step();
      chk($sformatf("v%0d_col", v), {31'd0, col_r}, {31'd0, vecs[v].col});
      wren_0 = 0; wren_1 = 0;
      address_0 = vecs[v].r0; address_1 = vecs[v].r1;
      step();
      chk($sformatf("v%0d_q0_reg", v), q0_r, vecs[v].e0);
      chk($sformatf("v%0d_q1_reg", v), q1_r, vecs[v].e1);
      chk($sformatf("v%0d_q0_comb", v), q0_c, vecs[v].e0);
      chk($sformatf("v%0d_q1_comb", v), q1_c, vecs[v].e1);
      chk($sformatf("v%0d_col_drop", v), {31'd0, col_r}, 32'd0);
    end

    // Read-during-write on word 2 (old 0, new 7)
    wren_0 = 1; address_0 = 32'h08; data_0 = 32'h7; byteen_0 = 4'hF;
    address_1 = 32'h0A;
    step();
    chk("rdw_reg_same_old", q0_r, 32'h0);
    chk("rdw_reg_other_old", q1_r, 32'h0);
    chk("rdw_comb_same_new", q0_c, 32'h7);
    chk("rdw_comb_other_new", q1_c, 32'h7);
    wren_0 = 0;
    step();
    chk("rdw_reg_same_next", q0_r, 32'h7);
    chk("rdw_reg_other_next", q1_r, 32'h7);
    step();
    chk("rdw_reg_hold", q1_r, 32'h7);

    // Reset while live, then mid-sweep reset at count 20
    address_0 = 32'h3C;
    step();
    chk("pre_reset_q0", q0_r, 32'hCAFEF00D);
    reset_n = 0;
    #1;
    chk("live_reset_ready", {31'd0, ready_r}, 32'd0);
    chk("live_reset_q0_reg", q0_r, 32'd0);
    chk("live_reset_q0_comb", q0_c, 32'd0);
    reset_n = 1;
    for (int k = 0; k < 21; k++) step();
    chk("mid_sweep_ready", {31'd0, ready_r}, 32'd0);
    reset_n = 0;
    #1;
    chk("mid_reset_ready", {31'd0, ready_r}, 32'd0);
    chk("mid_reset_q0", q0_r, 32'd0);
    reset_n = 1;
    wait_ready(n);
    chk("mid_reset_edges", n, 32'd65);
    step();
    chk("post_sweep_word15", q0_r, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
